mem_access_ctrl: RTL and testbench
==================================

# mem_access_ctrl

Memory-stage access controller between the EX_MEM and MEM_WB pipeline registers. Issues load/store requests to a variable-latency data memory, stalls the front of the pipeline until the access completes, and presents read data, address, and writeback control to MEM_WB. Misaligned accesses and memory timeouts produce a bubble and a one-cycle error pulse instead of hanging the CPU.

## Interface
Parameters:
- TIMEOUT, 16, max WAIT cycles before an access is abandoned (≥1)

Ports:
- clk  in  1  pipeline clock, rising edge
- rst  in  1  asynchronous, active-low reset
- MemRead_in  in  1  load from EX_MEM
- MemWrite_in  in  1  store from EX_MEM
- RegWrite_in  in  1  writeback enable from EX_MEM
- MemtoReg_in  in  2  writeback source select from EX_MEM
- ALU_result_in  in  32  byte address or ALU result
- write_data_in  in  32  store data
- EX_MEM_RegisterRd_in  in  5  destination register
- dmem_req  out  1  memory request, held until accepted
- dmem_we  out  1  1 = store
- dmem_addr  out  32  word-aligned byte address
- dmem_wdata  out  32  store data
- dmem_ready  in  1  memory completes request this cycle
- dmem_rdata  in  32  read data, valid with dmem_ready
- D_MEM_read_data_out  out  32  to MEM_WB
- D_MEM_read_addr_out  out  32  ALU_result_in pass-through to MEM_WB
- MEM_WB_RegisterRd_out  out  5  to MEM_WB
- RegWrite_out  out  1  to MEM_WB; 0 = bubble
- MemtoReg_out  out  2  to MEM_WB
- mem_stall  out  1  freeze PC, IF_ID, ID_EX, EX_MEM
- mem_error  out  1  one-cycle fault pulse

## Operation
- States: IDLE, WAIT, DONE. The memory op is `mem_op = MemRead_in | MemWrite_in`. The address is misaligned when `ALU_result_in[1:0] != 0`.
- IDLE, no mem_op: pure pass-through.
  - D_MEM_read_data_out = 0; other outputs follow their inputs.
  - dmem_req = 0, mem_stall = 0.
- IDLE, mem_op and misaligned:
  - No request is issued.
  - mem_error = 1, RegWrite_out = 0, mem_stall = 0.
  - State stays IDLE.
- IDLE, mem_op and aligned:
  - dmem_req = 1, dmem_we = MemWrite_in, dmem_addr = ALU_result_in, dmem_wdata = write_data_in.
  - If dmem_ready = 1: zero-wait completion. D_MEM_read_data_out = dmem_rdata for a load, 0 for a store. No stall. Stay in IDLE.
  - Otherwise: mem_stall = 1 and RegWrite_out = 0 (bubble). Next state is WAIT with the counter cleared.
- WAIT:
  - dmem_req stays 1 with identical address, data and we.
  - mem_stall = 1, RegWrite_out = 0.
  - On dmem_ready: capture dmem_rdata into rdata_q and go to DONE.
  - Otherwise the counter increments. When the counter reaches TIMEOUT−1 without ready: drop the request, set err_q, rdata_q = 0, go to DONE.
- DONE:
  - dmem_req = 0, mem_stall = 0.
  - D_MEM_read_data_out = rdata_q.
  - RegWrite_out = RegWrite_in & ~err_q.
  - mem_error = err_q.
  - Next state is IDLE; err_q clears.
- Inputs are stable during a stall because EX_MEM is frozen. Control and data fields other than RegWrite always reflect current inputs.
- MemRead_in and MemWrite_in both high is illegal. It is treated as a store.

## Timing
- Zero-wait access: 0 added cycles.
- N-wait access (ready in the Nth WAIT cycle, N ≥ 1): mem_stall high for N+1 cycles, then DONE for 1 cycle with no stall. Total added latency is N+1 cycles.
- Timeout: mem_stall high for TIMEOUT+1 cycles. mem_error is high for exactly 1 cycle, in DONE.
- Counter width is $clog2(TIMEOUT+1). It never wraps; it saturates by leaving WAIT.
- Reset: rst low forces state = IDLE, counter = 0, rdata_q = 0, err_q = 0. It also forces every output to 0, including dmem_req.
- Reset mid-WAIT abandons the request immediately. No completion is reported. The memory must tolerate a dropped dmem_req.
- A dmem_ready arriving in the same cycle as the timeout condition counts as success, not a timeout.
- dmem_ready while dmem_req = 0 is ignored.

## Structure
- cpu_defs.vh (shared, `include`d):
  - MemtoReg encodings: MTR_ALU = 2'b00, MTR_MEM = 2'b01, MTR_PC4 = 2'b10.
  - State localparams: S_IDLE = 2'd0, S_WAIT = 2'd1, S_DONE = 2'd2.
- One sub-module, mem_timeout_ctr: parameterised TIMEOUT, inputs clear/enable, output expired.
- The FSM and output mux live in mem_access_ctrl.

## Test plan
- Reset, then ALU op with RegWrite = 1, ALU_result_in = 0x0000_1234, rd = 5 → same-cycle pass-through; mem_stall = 0; dmem_req = 0.
- Load at 0x100, dmem_ready tied high, dmem_rdata = 0xDEAD_BEEF → no stall; D_MEM_read_data_out = 0xDEAD_BEEF; RegWrite_out = 1.
- Load at 0x200, ready on 3rd WAIT cycle with 0xCAFE_0001 → mem_stall high 4 cycles, RegWrite_out = 0 while stalled, then 1 DONE cycle with data 0xCAFE_0001 and RegWrite_out = 1.
- Store at 0x203 → dmem_req never rises; mem_error = 1 for 1 cycle; RegWrite_out = 0; no stall.
- Load at 0x300, ready never asserted, TIMEOUT = 16 → 17 stall cycles; DONE with data 0, mem_error = 1, RegWrite_out = 0; back to IDLE.
- rst driven low during WAIT cycle 2 → dmem_req and all outputs 0 asynchronously. After release: IDLE, and a fresh load completes normally.

Source files
------------

// File: rtl/mem_access_ctrl_pkg.sv
// Shared definitions for the memory-stage access controller.
//   state_e     : controller FSM states
//   MTR_*       : MemtoReg writeback source encodings
//   misaligned  : word-alignment test on a byte address
package mem_access_ctrl_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_DONE = 2'd2
  } state_e;

  localparam logic [1:0] MTR_ALU = 2'b00;
  localparam logic [1:0] MTR_MEM = 2'b01;
  localparam logic [1:0] MTR_PC4 = 2'b10;

  function automatic logic misaligned(input logic [31:0] addr);
    return addr[1:0] != 2'b00;
  endfunction

endpackage

// File: rtl/mem_access_ctrl_timeout_ctr.sv
// Wait-cycle counter for an outstanding memory access.
//   clk, rst : clock, async active-low reset
//   clear    : zero the count (held while no access is waiting)
//   enable   : count one more unanswered wait cycle
//   expired  : count has reached TIMEOUT-1; the current wait cycle is the last
// The count never passes TIMEOUT-1, so it cannot wrap.
module mem_timeout_ctr
  import mem_access_ctrl_pkg::*;
#(
  parameter int TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

  logic [CW-1:0] count;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                     count <= '0;
    else if (clear)               count <= '0;
    else if (enable && !expired)  count <= count + 1'b1;
  end

  assign expired = (count == LAST);

endmodule

// File: rtl/mem_access_ctrl.sv
// Memory-stage access controller between EX_MEM and MEM_WB.
//   clk, rst             : clock, async active-low reset (also zeroes all outputs)
//   *_in                 : EX_MEM control / data fields
//   dmem_*               : variable-latency data memory request / response
//   *_out                : MEM_WB fields; RegWrite_out = 0 marks a bubble
//   mem_stall            : freeze the front of the pipeline
//   mem_error            : one-cycle pulse on misalignment or timeout
// State is registered; outputs are a combinational mux of state and current
// inputs so that zero-wait accesses and plain ALU ops add no latency.
module mem_access_ctrl
  import mem_access_ctrl_pkg::*;
#(
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        MemRead_in,
  input  logic        MemWrite_in,
  input  logic        RegWrite_in,
  input  logic [1:0]  MemtoReg_in,
  input  logic [31:0] ALU_result_in,
  input  logic [31:0] write_data_in,
  input  logic [4:0]  EX_MEM_RegisterRd_in,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  input  logic        dmem_ready,
  input  logic [31:0] dmem_rdata,
  output logic [31:0] D_MEM_read_data_out,
  output logic [31:0] D_MEM_read_addr_out,
  output logic [4:0]  MEM_WB_RegisterRd_out,
  output logic        RegWrite_out,
  output logic [1:0]  MemtoReg_out,
  output logic        mem_stall,
  output logic        mem_error
);

  state_e      state;
  logic [31:0] rdata_q;
  logic        err_q;
  logic        expired;

  logic mem_op, mis, is_load;
  assign mem_op  = MemRead_in | MemWrite_in;
  assign mis     = misaligned(ALU_result_in);
  // Read+write together is illegal and handled as a store.
  assign is_load = MemRead_in & ~MemWrite_in;

  mem_timeout_ctr #(.TIMEOUT(TIMEOUT)) u_ctr (
    .clk     (clk),
    .rst     (rst),
    .clear   (state != S_WAIT),
    .enable  ((state == S_WAIT) && !dmem_ready),
    .expired (expired)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= S_IDLE;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          err_q <= 1'b0;
          if (mem_op && !mis && !dmem_ready) state <= S_WAIT;
        end
        S_WAIT: begin
          // Ready on the final wait cycle still wins over the timeout.
          if (dmem_ready) begin
            rdata_q <= dmem_rdata;
            err_q   <= 1'b0;
            state   <= S_DONE;
          end else if (expired) begin
            rdata_q <= '0;
            err_q   <= 1'b1;
            state   <= S_DONE;
          end
        end
        S_DONE: begin
          err_q <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    dmem_req              = 1'b0;
    dmem_we               = 1'b0;
    dmem_addr             = '0;
    dmem_wdata            = '0;
    D_MEM_read_data_out   = '0;
    D_MEM_read_addr_out   = '0;
    MEM_WB_RegisterRd_out = '0;
    RegWrite_out          = 1'b0;
    MemtoReg_out          = '0;
    mem_stall             = 1'b0;
    mem_error             = 1'b0;
    // Reset low gates every output, including a request in flight.
    if (rst) begin
      dmem_we               = MemWrite_in;
      dmem_addr             = {ALU_result_in[31:2], 2'b00};
      dmem_wdata            = write_data_in;
      D_MEM_read_addr_out   = ALU_result_in;
      MEM_WB_RegisterRd_out = EX_MEM_RegisterRd_in;
      MemtoReg_out          = MemtoReg_in;
      case (state)
        S_IDLE: begin
          if (!mem_op) begin
            RegWrite_out = RegWrite_in;
          end else if (mis) begin
            mem_error = 1'b1;
          end else begin
            dmem_req = 1'b1;
            if (dmem_ready) begin
              RegWrite_out        = RegWrite_in;
              D_MEM_read_data_out = is_load ? dmem_rdata : 32'h0;
            end else begin
              mem_stall = 1'b1;
            end
          end
        end
        S_WAIT: begin
          dmem_req  = 1'b1;
          mem_stall = 1'b1;
        end
        S_DONE: begin
          D_MEM_read_data_out = rdata_q;
          RegWrite_out        = RegWrite_in & ~err_q;
          mem_error           = err_q;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Self-checking bench for mem_access_ctrl (TIMEOUT = 16).
module tb_mem_access_ctrl;

  logic        clk, rst;
  logic        MemRead_in, MemWrite_in, RegWrite_in;
  logic [1:0]  MemtoReg_in;
  logic [31:0] ALU_result_in, write_data_in;
  logic [4:0]  EX_MEM_RegisterRd_in;
  logic        dmem_req, dmem_we, dmem_ready;
  logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic [31:0] D_MEM_read_data_out, D_MEM_read_addr_out;
  logic [4:0]  MEM_WB_RegisterRd_out;
  logic        RegWrite_out;
  logic [1:0]  MemtoReg_out;
  logic        mem_stall, mem_error;

  mem_access_ctrl #(.TIMEOUT(16)) dut (
    .clk                   (clk),
    .rst                   (rst),
    .MemRead_in            (MemRead_in),
    .MemWrite_in           (MemWrite_in),
    .RegWrite_in           (RegWrite_in),
    .MemtoReg_in           (MemtoReg_in),
    .ALU_result_in         (ALU_result_in),
    .write_data_in         (write_data_in),
    .EX_MEM_RegisterRd_in  (EX_MEM_RegisterRd_in),
    .dmem_req              (dmem_req),
    .dmem_we               (dmem_we),
    .dmem_addr             (dmem_addr),
    .dmem_wdata            (dmem_wdata),
    .dmem_ready            (dmem_ready),
    .dmem_rdata            (dmem_rdata),
    .D_MEM_read_data_out   (D_MEM_read_data_out),
    .D_MEM_read_addr_out   (D_MEM_read_addr_out),
    .MEM_WB_RegisterRd_out (MEM_WB_RegisterRd_out),
    .RegWrite_out          (RegWrite_out),
    .MemtoReg_out          (MemtoReg_out),
    .mem_stall             (mem_stall),
    .mem_error             (mem_error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    logic        stall, req, we, rwo, err, chkd;
    logic [31:0] addr, wdata, data, addr_out;
    logic [4:0]  rd;
    logic [1:0]  mtr;
  } exp_t;

  exp_t sb[$];
  int   n_chk  = 0;
  int   n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h want %h", tag, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic op(input logic mr, mw, rw, input logic [1:0] mtr,
                    input logic [31:0] alu, wd, input logic [4:0] rd);
    MemRead_in = mr; MemWrite_in = mw; RegWrite_in = rw; MemtoReg_in = mtr;
    ALU_result_in = alu; write_data_in = wd; EX_MEM_RegisterRd_in = rd;
  endtask

  task automatic rdy(input logic r, input logic [31:0] d);
    dmem_ready = r; dmem_rdata = d;
  endtask

  // Push the expectation for the cycle just driven, then compare it at negedge.
  task automatic expect_cyc(input string tag, input logic stall, req, rwo, err,
                            input logic chkd, input logic [31:0] data);
    exp_t e;
    e.tag = tag; e.stall = stall; e.req = req; e.rwo = rwo; e.err = err;
    e.chkd = chkd; e.data = data; e.we = MemWrite_in; e.addr = ALU_result_in;
    e.wdata = write_data_in; e.addr_out = ALU_result_in;
    e.rd = EX_MEM_RegisterRd_in; e.mtr = MemtoReg_in;
    sb.push_back(e);
    @(negedge clk);
    e = sb.pop_front();
    chk({e.tag, ".stall"}, 32'(mem_stall), 32'(e.stall));
    chk({e.tag, ".req"}, 32'(dmem_req), 32'(e.req));
    chk({e.tag, ".regwrite"}, 32'(RegWrite_out), 32'(e.rwo));
    chk({e.tag, ".error"}, 32'(mem_error), 32'(e.err));
    chk({e.tag, ".addr_out"}, D_MEM_read_addr_out, e.addr_out);
    chk({e.tag, ".rd"}, 32'(MEM_WB_RegisterRd_out), 32'(e.rd));
    chk({e.tag, ".mtr"}, 32'(MemtoReg_out), 32'(e.mtr));
    if (e.req) begin
      chk({e.tag, ".we"}, 32'(dmem_we), 32'(e.we));
      chk({e.tag, ".addr"}, dmem_addr, e.addr);
      chk({e.tag, ".wdata"}, dmem_wdata, e.wdata);
    end
    if (e.chkd) chk({e.tag, ".data"}, D_MEM_read_data_out, e.data);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, ".req"}, 32'(dmem_req), 0);
    chk({tag, ".we"}, 32'(dmem_we), 0);
    chk({tag, ".addr"}, dmem_addr, 0);
    chk({tag, ".wdata"}, dmem_wdata, 0);
    chk({tag, ".data"}, D_MEM_read_data_out, 0);
    chk({tag, ".addr_out"}, D_MEM_read_addr_out, 0);
    chk({tag, ".rd"}, 32'(MEM_WB_RegisterRd_out), 0);
    chk({tag, ".regwrite"}, 32'(RegWrite_out), 0);
    chk({tag, ".mtr"}, 32'(MemtoReg_out), 0);
    chk({tag, ".stall"}, 32'(mem_stall), 0);
    chk({tag, ".error"}, 32'(mem_error), 0);
  endtask

  initial begin
    rst = 1'b0;
    op(1, 0, 1, 2'b01, 32'h100, 32'h1234, 5'd3);
    rdy(1, 32'hDEAD_BEEF);
    #7;
    chk_all_zero("reset");
    @(negedge clk);
    rst = 1'b1;

    // Plain ALU op: same-cycle pass-through.
    tick(); op(0, 0, 1, 2'b00, 32'h0000_1234, 32'h0, 5'd5); rdy(0, 0);
    expect_cyc("alu", 0, 0, 1, 0, 1, 32'h0);
    // Ready with no request is ignored.
    tick(); op(0, 0, 1, 2'b10, 32'h88, 32'h0, 5'd7); rdy(1, 32'h5555_AAAA);
    expect_cyc("rdy_noreq", 0, 0, 1, 0, 1, 32'h0);

    // Zero-wait load.
    tick(); op(1, 0, 1, 2'b01, 32'h100, 32'h0, 5'd3); rdy(1, 32'hDEAD_BEEF);
    expect_cyc("zw_load", 0, 1, 1, 0, 1, 32'hDEAD_BEEF);
    // Read+write together behaves as a zero-wait store: we=1, no read data.
    tick(); op(1, 1, 0, 2'b00, 32'h104, 32'h1234_5678, 5'd0); rdy(1, 32'hFFFF_0000);
    expect_cyc("zw_rdwr", 0, 1, 0, 0, 1, 32'h0);

    // Load ready on 3rd wait cycle: 4 stall cycles then DONE.
    tick(); op(1, 0, 1, 2'b01, 32'h200, 32'h0, 5'd9); rdy(0, 0);
    expect_cyc("w3_idle", 1, 1, 0, 0, 0, 32'h0);
    for (int i = 1; i <= 3; i++) begin
      tick(); rdy(i == 3, (i == 3) ? 32'hCAFE_0001 : 32'h0);
      expect_cyc($sformatf("w3_wait%0d", i), 1, 1, 0, 0, 0, 32'h0);
    end
    tick(); rdy(0, 32'h1111_1111);
    expect_cyc("w3_done", 0, 0, 1, 0, 1, 32'hCAFE_0001);

    // Misaligned store: no request, one error pulse, bubble.
    tick(); op(0, 1, 1, 2'b00, 32'h203, 32'hAAAA_5555, 5'd4); rdy(0, 0);
    expect_cyc("mis_store", 0, 0, 0, 1, 1, 32'h0);
    tick(); op(0, 0, 1, 2'b00, 32'h10, 32'h0, 5'd4);
    expect_cyc("mis_after", 0, 0, 1, 0, 1, 32'h0);

    // Timeout: 17 stall cycles then DONE with error.
    tick(); op(1, 0, 1, 2'b01, 32'h300, 32'h0, 5'd6); rdy(0, 0);
    expect_cyc("to_idle", 1, 1, 0, 0, 0, 32'h0);
    for (int i = 1; i <= 16; i++) begin
      tick();
      expect_cyc($sformatf("to_wait%0d", i), 1, 1, 0, 0, 0, 32'h0);
    end
    tick();
    expect_cyc("to_done", 0, 0, 0, 1, 1, 32'h0);
    tick(); op(0, 0, 1, 2'b00, 32'h20, 32'h0, 5'd6);
    expect_cyc("to_after", 0, 0, 1, 0, 1, 32'h0);

    // Ready on the last possible wait cycle counts as success.
    tick(); op(1, 0, 1, 2'b01, 32'h304, 32'h0, 5'd8); rdy(0, 0);
    expect_cyc("edge_idle", 1, 1, 0, 0, 0, 32'h0);
    for (int i = 1; i <= 16; i++) begin
      tick(); rdy(i == 16, (i == 16) ? 32'h0BAD_F00D : 32'h0);
      expect_cyc($sformatf("edge_wait%0d", i), 1, 1, 0, 0, 0, 32'h0);
    end
    tick(); rdy(0, 0);
    expect_cyc("edge_done", 0, 0, 1, 0, 1, 32'h0BAD_F00D);

    // Reset asserted during wait cycle 2.
    tick(); op(1, 0, 1, 2'b01, 32'h400, 32'h0, 5'd2); rdy(0, 0);
    expect_cyc("rst_idle", 1, 1, 0, 0, 0, 32'h0);
    tick();
    expect_cyc("rst_wait1", 1, 1, 0, 0, 0, 32'h0);
    tick();
    #2 rst = 1'b0;
    #1 chk_all_zero("rst_mid");
    @(negedge clk);
    chk_all_zero("rst_hold");
    // With ready high, IDLE completes at once while WAIT would still stall.
    rdy(1, 32'h7777_0000);
    rst = 1'b1;
    #1;
    chk("post_rst.stall", 32'(mem_stall), 0);
    chk("post_rst.data", D_MEM_read_data_out, 32'h7777_0000);

    // Fresh load after reset, one wait cycle.
    tick(); op(1, 0, 1, 2'b01, 32'h500, 32'h0, 5'd11); rdy(0, 0);
    expect_cyc("fresh_idle", 1, 1, 0, 0, 0, 32'h0);
    tick(); rdy(1, 32'h5005_0005);
    expect_cyc("fresh_wait", 1, 1, 0, 0, 0, 32'h0);
    tick(); rdy(0, 0);
    expect_cyc("fresh_done", 0, 0, 1, 0, 1, 32'h5005_0005);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
